// File: rtl/data_memory.sv
// Word-organised data memory for the MEM stage: combinational loads, clocked stores,
// a post-reset clear sweep that gates mem_ready, and a sticky access-error flag.
module data_memory #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_ctrl_input,
  input  logic [31:0] address,
  input  logic [31:0] w_data,
  output logic [31:0] read_data,
  output logic        mem_ready,
  output logic        mem_error
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [32:0] DEPTH_W = 33'(1) << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_STORE = 2'b01;
  localparam logic [1:0] CMD_LOAD  = 2'b10;
  localparam logic [1:0] CMD_ILL   = 2'b11;

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] clr_ptr_q, clr_ptr_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;

  logic [31:0]           mem_q [DEPTH];
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;
  logic [31:0]           mem_wdata;

  logic [31:0]           off;
  logic                  addr_valid;
  logic [DEPTH_LOG2-1:0] idx;

  // Addresses below BASE_ADDR wrap to a huge offset; the explicit compare keeps them out of range.
  assign off        = address - BASE_ADDR;
  assign addr_valid = (off[1:0] == 2'b00) && (address >= BASE_ADDR)
                      && ({3'b000, off[31:2]} < DEPTH_W);
  assign idx        = off[DEPTH_LOG2+1:2];

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = clr_ptr_q;
    mem_wdata = '0;
    read_data = '0;
    case (state_q)
      S_CLEAR: begin
        mem_we    = !reset;
        clr_ptr_d = clr_ptr_q + DEPTH_LOG2'(1);
        if (clr_ptr_q == LAST_IDX) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        case (mem_ctrl_input)
          CMD_STORE: begin
            if (addr_valid) begin
              mem_we    = !reset;
              mem_waddr = idx;
              mem_wdata = w_data;
            end else begin
              err_d = 1'b1;
            end
          end
          CMD_LOAD: begin
            if (addr_valid) begin
              read_data = mem_q[idx];
            end else begin
              err_d = 1'b1;
            end
          end
          CMD_ILL:  err_d = 1'b1;
          CMD_IDLE: err_d = err_q;
          default:  err_d = err_q;
        endcase
      end
      default: state_d = S_CLEAR;
    endcase
    ready_d = (state_d == S_READY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_CLEAR;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  // Storage has no reset; the sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign mem_ready = ready_q;
  assign mem_error = err_q;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: two 16-word instances (base 0 and base 0x1000) exercised with
// a vector table for dut0 and hand sequences for sweep, reset and range corner cases.
module tb_data_memory;

  logic        clk;
  logic        reset;
  logic [1:0]  cmd0, cmd1;
  logic [31:0] addr0, addr1, wd0, wd1;
  logic [31:0] rd0, rd1;
  logic        rdy0, rdy1, err0, err1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t vecs[$];

  data_memory #(.DEPTH_LOG2(4), .BASE_ADDR(32'h0000_0000)) dut0 (
    .clk(clk), .reset(reset), .mem_ctrl_input(cmd0), .address(addr0), .w_data(wd0),
    .read_data(rd0), .mem_ready(rdy0), .mem_error(err0)
  );

  data_memory #(.DEPTH_LOG2(4), .BASE_ADDR(32'h0000_1000)) dut1 (
    .clk(clk), .reset(reset), .mem_ctrl_input(cmd1), .address(addr1), .w_data(wd1),
    .read_data(rd1), .mem_ready(rdy1), .mem_error(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    cmd0 = 2'b00; cmd1 = 2'b00;
    addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;
  endtask

  // Called at posedge+1; drives one access, checks load data mid-cycle and the error flag after the edge.
  task automatic access(input int sel, input logic [1:0] cmd, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input string name);
    exp_t e;
    if (sel == 0) begin
      cmd0 = cmd; addr0 = addr; wd0 = wd;
    end else begin
      cmd1 = cmd; addr1 = addr; wd1 = wd;
    end
    e.name = name; e.rd = exp_rd; e.err = exp_err;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check32($sformatf("%s rd", e.name), (sel != 0) ? rd1 : rd0, e.rd);
    @(posedge clk);
    #1;
    check32($sformatf("%s err", e.name), {31'b0, (sel != 0) ? err1 : err0}, {31'b0, e.err});
    idle_all();
  endtask

  // Called at posedge+1 with reset just released; expects ready to rise after exactly 16 edges.
  task automatic sweep(input string name);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      check32($sformatf("%s rdy0 e%0d", name, i), {31'b0, rdy0}, {31'b0, (i == 16)});
      check32($sformatf("%s rdy1 e%0d", name, i), {31'b0, rdy1}, {31'b0, (i == 16)});
      if (i == 8) begin
        check32($sformatf("%s sweep load rd0", name), rd0, 32'h0);
      end
    end
    idle_all();
  endtask

  initial begin
    idle_all();
    reset = 1'b1;
    #1;
    check32("rst rdy0", {31'b0, rdy0}, 32'h0);
    check32("rst err0", {31'b0, err0}, 32'h0);
    check32("rst rd0", rd0, 32'h0);
    check32("rst rdy1", {31'b0, rdy1}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    // Commands during the sweep must be ignored: load returns 0, illegal does not set the error.
    cmd0 = 2'b10; addr0 = 32'h0;
    cmd1 = 2'b11; addr1 = 32'h0;
    sweep("sweep1");
    check32("sweep ignored illegal err1", {31'b0, err1}, 32'h0);

    for (int a = 0; a < 16; a++) begin
      vecs.push_back('{2'b10, 32'(a * 4), 32'h0, 32'h0, 1'b0});
    end
    vecs.push_back('{2'b01, 32'h08, 32'hDEADBEEF, 32'h0, 1'b0});
    vecs.push_back('{2'b10, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{2'b10, 32'h0C, 32'h0, 32'h0, 1'b0});
    vecs.push_back('{2'b01, 32'h04, 32'h11111111, 32'h0, 1'b0});
    vecs.push_back('{2'b10, 32'h04, 32'h0, 32'h11111111, 1'b0});
    vecs.push_back('{2'b00, 32'h03, 32'h0, 32'h0, 1'b0});
    vecs.push_back('{2'b00, 32'h08, 32'h0, 32'h0, 1'b0});
    vecs.push_back('{2'b01, 32'h06, 32'h12345678, 32'h0, 1'b1});
    vecs.push_back('{2'b10, 32'h04, 32'h0, 32'h11111111, 1'b1});
    vecs.push_back('{2'b10, 32'h08, 32'h0, 32'hDEADBEEF, 1'b1});
    vecs.push_back('{2'b01, 32'h3C, 32'hAAAA5555, 32'h0, 1'b1});
    vecs.push_back('{2'b10, 32'h3C, 32'h0, 32'hAAAA5555, 1'b1});
    vecs.push_back('{2'b01, 32'h40, 32'h55555555, 32'h0, 1'b1});
    vecs.push_back('{2'b10, 32'h40, 32'h0, 32'h0, 1'b1});
    vecs.push_back('{2'b10, 32'h00, 32'h0, 32'h0, 1'b1});
    for (int i = 0; i < vecs.size(); i++) begin
      access(0, vecs[i].cmd, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_err,
             $sformatf("vec%0d", i));
    end

    access(1, 2'b01, 32'h0000_103C, 32'hCAFEF00D, 32'h0, 1'b0, "b1 store 103C");
    access(1, 2'b10, 32'h0000_103C, 32'h0, 32'hCAFEF00D, 1'b0, "b1 load 103C");
    access(1, 2'b10, 32'h0000_1000, 32'h0, 32'h0, 1'b0, "b1 load 1000");
    access(1, 2'b10, 32'h0000_0FFC, 32'h0, 32'h0, 1'b1, "b1 load 0FFC");

    // Reset in READY drops ready and error immediately.
    reset = 1'b1;
    #1;
    check32("rst ready rdy0", {31'b0, rdy0}, 32'h0);
    check32("rst ready err0", {31'b0, err0}, 32'h0);
    check32("rst ready err1", {31'b0, err1}, 32'h0);
    check32("rst ready rd0", rd0, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check32("mid sweep rdy0", {31'b0, rdy0}, 32'h0);
    reset = 1'b1;
    #2;
    check32("mid rst rdy0", {31'b0, rdy0}, 32'h0);
    check32("mid rst err0", {31'b0, err0}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sweep("sweep2");

    access(0, 2'b10, 32'h08, 32'h0, 32'h0, 1'b0, "cleared 08");
    access(0, 2'b10, 32'h3C, 32'h0, 32'h0, 1'b0, "cleared 3C");
    access(1, 2'b10, 32'h0000_103C, 32'h0, 32'h0, 1'b0, "b1 cleared 103C");
    access(0, 2'b11, 32'h00, 32'hFFFFFFFF, 32'h0, 1'b1, "illegal cmd");
    access(0, 2'b10, 32'h00, 32'h0, 32'h0, 1'b1, "after illegal 00");
    access(1, 2'b00, 32'h0000_1003, 32'h0, 32'h0, 1'b0, "b1 idle 1003");
    access(1, 2'b10, 32'h0000_1040, 32'h0, 32'h0, 1'b1, "b1 load 1040");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
